// File: rtl/serial_display_receiver.sv
`default_nettype none
// ============================================================================
// Module   : serial_display_receiver
// Brief    : 3-wire serial display link receiver; deserializes 48-bit frames
//            and decodes six 7-segment digits back to BCD + decimal points.
// Revision : 1.0 - initial release
// ============================================================================
module serial_display_receiver #(
    parameter int SHIFT_WIDTH = 48,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   i_serial_data,
    input  logic                   i_serial_clk,
    input  logic                   i_serial_latch,
    output logic [SHIFT_WIDTH-1:0] o_parallel_data,
    output logic [3:0]             o_hours_msb,
    output logic [3:0]             o_hours_lsb,
    output logic [3:0]             o_minutes_msb,
    output logic [3:0]             o_minutes_lsb,
    output logic [3:0]             o_seconds_msb,
    output logic [3:0]             o_seconds_lsb,
    output logic                   o_dp_hours1,
    output logic                   o_dp_hours2,
    output logic                   o_dp_minutes1,
    output logic                   o_dp_minutes2,
    output logic                   o_dp_seconds1,
    output logic                   o_dp_seconds2,
    output logic [5:0]             o_blank,
    output logic [5:0]             o_decode_err,
    output logic                   o_valid_stb,
    output logic                   o_frame_err_stb,
    output logic                   o_busy
);

    localparam int               NUM_DIGITS = 6;
    localparam int               CNT_W      = $clog2(SHIFT_WIDTH + 2);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(SHIFT_WIDTH);
    localparam logic [CNT_W-1:0] CNT_SAT    = CNT_W'(SHIFT_WIDTH + 1);

    logic [SYNC_STAGES-1:0] sync_data;
    logic [SYNC_STAGES-1:0] sync_sclk;
    logic [SYNC_STAGES-1:0] sync_latch;
    logic                   sclk_hist;
    logic                   latch_hist;

    logic                   data_s;
    logic                   sclk_rise;
    logic                   latch_rise;

    logic [SHIFT_WIDTH-1:0] shreg;
    logic [SHIFT_WIDTH-1:0] shreg_next;
    logic [SHIFT_WIDTH-1:0] frame_q;
    logic [CNT_W-1:0]       count;
    logic [CNT_W-1:0]       count_next;
    logic                   good_q;
    logic                   bad_q;

    logic [5:0]             dec [NUM_DIGITS];

    logic [NUM_DIGITS-1:0][3:0] digit_r;
    logic [NUM_DIGITS-1:0]      dp_r;
    logic [NUM_DIGITS-1:0]      blank_r;
    logic [NUM_DIGITS-1:0]      err_r;

    assign data_s     = sync_data[SYNC_STAGES-1];
    assign sclk_rise  = sync_sclk[SYNC_STAGES-1] & ~sclk_hist;
    assign latch_rise = sync_latch[SYNC_STAGES-1] & ~latch_hist;

    // Shift is resolved before the latch so a coincident latch sees the post-shift frame.
    always_comb begin
        shreg_next = shreg;
        count_next = count;
        if (sclk_rise) begin
            shreg_next = {shreg[SHIFT_WIDTH-2:0], data_s};
            if (count != CNT_SAT) begin
                count_next = count + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            sync_data  <= '0;
            sync_sclk  <= '0;
            sync_latch <= '0;
            sclk_hist  <= 1'b0;
            latch_hist <= 1'b0;
            shreg      <= '0;
            count      <= '0;
            frame_q    <= '0;
            good_q     <= 1'b0;
            bad_q      <= 1'b0;
        end else begin
            sync_data  <= {sync_data[SYNC_STAGES-2:0], i_serial_data};
            sync_sclk  <= {sync_sclk[SYNC_STAGES-2:0], i_serial_clk};
            sync_latch <= {sync_latch[SYNC_STAGES-2:0], i_serial_latch};
            sclk_hist  <= sync_sclk[SYNC_STAGES-1];
            latch_hist <= sync_latch[SYNC_STAGES-1];
            shreg      <= shreg_next;
            count      <= latch_rise ? '0 : count_next;
            good_q     <= latch_rise && (count_next == CNT_FULL);
            bad_q      <= latch_rise && (count_next != CNT_FULL);
            if (latch_rise) begin
                frame_q <= shreg_next;
            end
        end
    end

    // Returns {digit[3:0], blank, decode_err}.
    function automatic logic [5:0] decode_seg(input logic [6:0] seg);
        case (seg)
            7'h3F:   return {4'd0, 2'b00};
            7'h06:   return {4'd1, 2'b00};
            7'h5B:   return {4'd2, 2'b00};
            7'h4F:   return {4'd3, 2'b00};
            7'h66:   return {4'd4, 2'b00};
            7'h6D:   return {4'd5, 2'b00};
            7'h7D:   return {4'd6, 2'b00};
            7'h07:   return {4'd7, 2'b00};
            7'h7F:   return {4'd8, 2'b00};
            7'h6F:   return {4'd9, 2'b00};
            7'h00:   return {4'hF, 2'b10};
            default: return {4'hE, 2'b01};
        endcase
    endfunction

    // Digit index 0 is the last byte on the wire (seconds_lsb), index 5 the first.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_dec
            assign dec[gi] = decode_seg(frame_q[8*gi +: 7]);
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_parallel_data <= '0;
            digit_r         <= {NUM_DIGITS{4'hF}};
            dp_r            <= '0;
            blank_r         <= '1;
            err_r           <= '0;
            o_valid_stb     <= 1'b0;
            o_frame_err_stb <= 1'b0;
        end else begin
            o_valid_stb     <= good_q;
            o_frame_err_stb <= bad_q;
            if (good_q) begin
                o_parallel_data <= frame_q;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digit_r[i] <= dec[i][5:2];
                    blank_r[i] <= dec[i][1];
                    err_r[i]   <= dec[i][0];
                    dp_r[i]    <= frame_q[8*i+7];
                end
            end
        end
    end

    assign o_hours_msb   = digit_r[5];
    assign o_hours_lsb   = digit_r[4];
    assign o_minutes_msb = digit_r[3];
    assign o_minutes_lsb = digit_r[2];
    assign o_seconds_msb = digit_r[1];
    assign o_seconds_lsb = digit_r[0];
    assign o_dp_hours1   = dp_r[5];
    assign o_dp_hours2   = dp_r[4];
    assign o_dp_minutes1 = dp_r[3];
    assign o_dp_minutes2 = dp_r[2];
    assign o_dp_seconds1 = dp_r[1];
    assign o_dp_seconds2 = dp_r[0];
    assign o_blank       = blank_r;
    assign o_decode_err  = err_r;
    assign o_busy        = (count != '0);

endmodule
`default_nettype wire

// File: tb/tb_serial_display_receiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_display_receiver
// Brief    : Directed self-checking bench for serial_display_receiver.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_display_receiver;

    localparam int SHIFT_WIDTH = 48;
    localparam int SYNC_STAGES = 2;
    localparam int LATENCY     = SYNC_STAGES + 2;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic                   sdata = 1'b0;
    logic                   sclk = 1'b0;
    logic                   slatch = 1'b0;
    logic [SHIFT_WIDTH-1:0] parallel;
    logic [3:0]             h_msb, h_lsb, m_msb, m_lsb, s_msb, s_lsb;
    logic                   dp_h1, dp_h2, dp_m1, dp_m2, dp_s1, dp_s2;
    logic [5:0]             blank, derr;
    logic                   valid_stb, ferr_stb, busy;

    int vectors     = 0;
    int miscompares = 0;
    int vcnt, ecnt, vfirst, efirst;

    serial_display_receiver #(
        .SHIFT_WIDTH (SHIFT_WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .i_clk           (clk),
        .i_reset         (rst),
        .i_serial_data   (sdata),
        .i_serial_clk    (sclk),
        .i_serial_latch  (slatch),
        .o_parallel_data (parallel),
        .o_hours_msb     (h_msb),
        .o_hours_lsb     (h_lsb),
        .o_minutes_msb   (m_msb),
        .o_minutes_lsb   (m_lsb),
        .o_seconds_msb   (s_msb),
        .o_seconds_lsb   (s_lsb),
        .o_dp_hours1     (dp_h1),
        .o_dp_hours2     (dp_h2),
        .o_dp_minutes1   (dp_m1),
        .o_dp_minutes2   (dp_m2),
        .o_dp_seconds1   (dp_s1),
        .o_dp_seconds2   (dp_s2),
        .o_blank         (blank),
        .o_decode_err    (derr),
        .o_valid_stb     (valid_stb),
        .o_frame_err_stb (ferr_stb),
        .o_busy          (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        sdata = b;
        sclk  = 1'b0;
        repeat (3) @(negedge clk);
        sclk  = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    // Sends the first nbits of frame, MSB first (nbits may exceed the width).
    task automatic send_bits(input logic [SHIFT_WIDTH-1:0] frame, input int nbits);
        logic [SHIFT_WIDTH-1:0] f;
        f = frame;
        for (int i = 0; i < nbits; i++) begin
            send_bit(f[SHIFT_WIDTH-1]);
            f = {f[SHIFT_WIDTH-2:0], 1'b0};
        end
    endtask

    // Raises the latch (optionally together with a serial clock rise) and
    // watches both strobes for a bounded window.
    task automatic latch_watch(input logic with_clk);
        vcnt = 0; ecnt = 0; vfirst = -1; efirst = -1;
        @(negedge clk);
        slatch = 1'b1;
        if (with_clk) sclk = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk);
            #1;
            if (valid_stb) begin vcnt++; if (vfirst < 0) vfirst = k; end
            if (ferr_stb)  begin ecnt++; if (efirst < 0) efirst = k; end
        end
        @(negedge clk);
        slatch = 1'b0;
        sclk   = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic check_digits(input string tag, input logic [23:0] exp);
        check({tag, ".digits"}, {40'd0, h_msb, h_lsb, m_msb, m_lsb, s_msb, s_lsb}, {40'd0, exp});
    endtask

    task automatic check_reset_state(input string tag);
        check_digits(tag, 24'hFFFFFF);
        check({tag, ".blank"},    {58'd0, blank}, 64'h3F);
        check({tag, ".derr"},     {58'd0, derr}, 64'h0);
        check({tag, ".parallel"}, {16'd0, parallel}, 64'h0);
        check({tag, ".dp"},       {58'd0, dp_h1, dp_h2, dp_m1, dp_m2, dp_s1, dp_s2}, 64'h0);
        check({tag, ".busy"},     {63'd0, busy}, 64'h0);
        check({tag, ".strobes"},  {62'd0, valid_stb, ferr_stb}, 64'h0);
    endtask

    localparam logic [SHIFT_WIDTH-1:0] F_123456 = 48'h06_DB_4F_66_6D_7D;
    localparam logic [SHIFT_WIDTH-1:0] F_235987 = 48'h5B_4F_6D_6F_7F_07;
    localparam logic [SHIFT_WIDTH-1:0] F_BADHMS = 48'h49_5B_4F_66_6D_7D;
    localparam logic [SHIFT_WIDTH-1:0] F_BLANK  = 48'h0;

    initial begin
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Good frame 12:34:56 with dp_hours2
        send_bits(F_123456, 48);
        check("good1.busy_before", {63'd0, busy}, 64'h1);
        latch_watch(1'b0);
        check("good1.vcnt",   vcnt, 1);
        check("good1.vlat",   vfirst, LATENCY);
        check("good1.ecnt",   ecnt, 0);
        check_digits("good1", 24'h123456);
        check("good1.dp",     {58'd0, dp_h1, dp_h2, dp_m1, dp_m2, dp_s1, dp_s2}, 64'b010000);
        check("good1.blank",  {58'd0, blank}, 64'h0);
        check("good1.derr",   {58'd0, derr}, 64'h0);
        check("good1.parallel", {16'd0, parallel}, {16'd0, F_123456});
        check("good1.busy_after", {63'd0, busy}, 64'h0);

        // Short frame: 47 clocks
        send_bits(F_235987, 47);
        latch_watch(1'b0);
        check("short.ecnt", ecnt, 1);
        check("short.elat", efirst, LATENCY);
        check("short.vcnt", vcnt, 0);
        check_digits("short", 24'h123456);
        check("short.parallel", {16'd0, parallel}, {16'd0, F_123456});
        check("short.busy", {63'd0, busy}, 64'h0);

        // Following good frame 23:59:87
        send_bits(F_235987, 48);
        latch_watch(1'b0);
        check("good2.vcnt", vcnt, 1);
        check_digits("good2", 24'h235987);
        check("good2.dp", {58'd0, dp_h1, dp_h2, dp_m1, dp_m2, dp_s1, dp_s2}, 64'h0);
        check("good2.parallel", {16'd0, parallel}, {16'd0, F_235987});

        // Overflow: 49 clocks
        send_bits({F_123456[SHIFT_WIDTH-2:0], 1'b1}, 49);
        latch_watch(1'b0);
        check("ovf.ecnt", ecnt, 1);
        check("ovf.vcnt", vcnt, 0);
        check_digits("ovf", 24'h235987);

        // Blank display
        send_bits(F_BLANK, 48);
        latch_watch(1'b0);
        check("blank.vcnt", vcnt, 1);
        check_digits("blank", 24'hFFFFFF);
        check("blank.blank", {58'd0, blank}, 64'h3F);
        check("blank.derr",  {58'd0, derr}, 64'h0);

        // Illegal hours_msb pattern
        send_bits(F_BADHMS, 48);
        latch_watch(1'b0);
        check("bad.vcnt", vcnt, 1);
        check_digits("bad", 24'hE23456);
        check("bad.derr",  {58'd0, derr}, 64'h20);
        check("bad.blank", {58'd0, blank}, 64'h0);

        // 48th clock rise coincident with latch rise
        send_bits(F_123456, 47);
        @(negedge clk);
        sdata = F_123456[0];
        sclk  = 1'b0;
        repeat (3) @(negedge clk);
        latch_watch(1'b1);
        check("coinc.vcnt", vcnt, 1);
        check("coinc.ecnt", ecnt, 0);
        check_digits("coinc", 24'h123456);
        check("coinc.parallel", {16'd0, parallel}, {16'd0, F_123456});

        // Reset mid-frame
        send_bits(F_235987, 20);
        check("midrst.busy_before", {63'd0, busy}, 64'h1);
        @(negedge clk);
        rst   = 1'b1;
        sdata = 1'b0;
        sclk  = 1'b0;
        #1;
        check_reset_state("midrst");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        send_bits(F_235987, 48);
        latch_watch(1'b0);
        check("postrst.vcnt", vcnt, 1);
        check("postrst.ecnt", ecnt, 0);
        check_digits("postrst", 24'h235987);
        check("postrst.parallel", {16'd0, parallel}, {16'd0, F_235987});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
